// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies a 5-bit shift as a sequence of 4-bit and 1-bit
// steps, using the SLL/SRL/SRA select encoding of the combinational shift stages.
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] B,
  input  logic [4:0]  shamt,
  input  logic [1:0]  ALUfun,
  output logic [31:0] y,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_rem;
  logic [1:0]  r_type;

  logic        w_step4;
  logic [4:0]  w_step;
  logic [4:0]  w_rem_next;
  logic [31:0] w_shifted;

  // Large steps first while at least 4 bits remain, then single-bit steps.
  assign w_step4    = (r_rem >= 5'd4);
  assign w_step     = w_step4 ? 5'd4 : 5'd1;
  assign w_rem_next = r_rem - w_step;

  // Bit 1 of the type selects arithmetic, so 10 and 11 both mean SRA.
  always_comb begin
    w_shifted = r_acc;
    if (r_type[1]) begin
      w_shifted = w_step4 ? {{4{r_acc[31]}}, r_acc[31:4]} : {r_acc[31], r_acc[31:1]};
    end else if (r_type[0]) begin
      w_shifted = w_step4 ? {4'b0000, r_acc[31:4]} : {1'b0, r_acc[31:1]};
    end else begin
      w_shifted = w_step4 ? {r_acc[27:0], 4'b0000} : {r_acc[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_acc   <= 32'd0;
      r_rem   <= 5'd0;
      r_type  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc   <= B;
            r_rem   <= shamt;
            r_type  <= ALUfun;
            r_state <= (shamt == 5'd0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= w_rem_next;
          if (w_rem_next == 5'd0) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign y    = r_acc;
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a result/latency model built from shift operators
// and step counts, checked every cycle, plus directed literal expectations.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [1:0]  ALUfun;
  logic [31:0] y;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  logic chk_en;

  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .B(B), .shamt(shamt),
    .ALUfun(ALUfun), .y(y), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [1:0] f, input logic [31:0] b,
                                            input logic [4:0] s);
    if (f == 2'b00) return b << s;
    else if (f == 2'b01) return b >> s;
    else return 32'($signed(b) >>> s);
  endfunction

  function automatic int ref_steps(input logic [4:0] s);
    return int'(s) / 4 + int'(s) % 4;
  endfunction

  // Model: result computed in one go; only the cycle count to done is tracked.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_y    = 32'd0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_y <= 32'd0; m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) m_done <= 1'b1;
      m_left <= m_left - 1;
    end else if (start) begin
      m_busy <= 1'b1;
      m_y    <= ref_shift(ALUfun, B, shamt);
      m_left <= ref_steps(shamt);
      m_done <= (shamt == 5'd0);
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] b,
                        input logic [4:0] s, input int exp_cyc, input logic [31:0] exp_y);
    int seen;
    seen = 0;
    @(negedge clk);
    ALUfun = f; B = b; shamt = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; B = $urandom(); shamt = 5'($urandom()); ALUfun = 2'($urandom());
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk);
      if (done) seen = c;
    end
    check_int({name, " done_cycle"}, seen, exp_cyc);
    check32({name, " y"}, y, exp_y);
    $display("op %s: done_cycle=%0d y=%h", name, seen, y);
  endtask

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0;
    reset = 1'b1; start = 1'b0; B = '0; shamt = '0; ALUfun = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset y", y, 32'd0);
    check32("reset busy", {31'd0, busy}, 32'd0);
    check32("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    fork
      begin
        forever begin
          @(negedge clk);
          if (chk_en) begin
            check32("model busy", {31'd0, busy}, {31'd0, m_busy});
            check32("model done", {31'd0, done}, {31'd0, m_done});
            if (!m_busy || m_done) check32("model y", y, m_y);
          end
        end
      end
      begin
        int ndone;
        int dcyc;
        int mask;

        run_op("sll5",    2'b00, 32'h0000_0001, 5'd5,  3,  32'h0000_0020);
        run_op("sra31",   2'b11, 32'h8000_0000, 5'd31, 11, 32'hFFFF_FFFF);
        run_op("sra31_10",2'b10, 32'h8000_0000, 5'd31, 11, 32'hFFFF_FFFF);
        run_op("srl4",    2'b01, 32'hF000_0000, 5'd4,  2,  32'h0F00_0000);
        run_op("zero",    2'b00, 32'h1234_5678, 5'd0,  1,  32'h1234_5678);
        run_op("sll7",    2'b00, 32'hA5A5_A5A5, 5'd7,  5,  32'hD2D2_D280);
        run_op("sra6pos", 2'b11, 32'h7000_0000, 5'd6,  4,  32'h01C0_0000);

        // Start pulse while busy must be ignored.
        @(negedge clk);
        ALUfun = 2'b01; B = 32'hFFFF_FFFF; shamt = 5'd3; start = 1'b1;
        ndone = 0; dcyc = 0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
          @(negedge clk);
          if (done) begin ndone++; dcyc = c; end
          if (c == 2) begin start = 1'b1; B = 32'd0; end
          if (c == 3) start = 1'b0;
          if (c == 4) check32("busy_start y", y, 32'h1FFF_FFFF);
        end
        check_int("busy_start done_count", ndone, 1);
        check_int("busy_start done_cycle", dcyc, 4);
        $display("op busy_start: done_count=%0d done_cycle=%0d", ndone, dcyc);

        // Reset in cycle 2 of a long shift aborts it without a done pulse.
        @(negedge clk);
        ALUfun = 2'b00; B = 32'h0000_0001; shamt = 5'd20; start = 1'b1;
        ndone = 0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
          @(negedge clk);
          if (done) ndone++;
          if (c == 2) begin reset = 1'b1; start = 1'b1; end
          if (c == 3) begin
            check32("abort busy", {31'd0, busy}, 32'd0);
            check32("abort y", y, 32'd0);
            reset = 1'b0; start = 1'b0;
          end
        end
        check_int("abort done_count", ndone, 0);
        $display("op abort: done_count=%0d y=%h", ndone, y);

        // Start coinciding with reset in IDLE is dropped.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; B = 32'h0000_00FF; shamt = 5'd0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check32("reset_start busy", {31'd0, busy}, 32'd0);
        check32("reset_start done", {31'd0, done}, 32'd0);
        $display("op reset_start: busy=%0d done=%0d", busy, done);

        run_op("after_abort", 2'b00, 32'h0000_0001, 5'd20, 6, 32'h0010_0000);

        // Back-to-back with start held high: accepts every third edge.
        @(negedge clk);
        ALUfun = 2'b00; B = 32'h0000_0001; shamt = 5'd1; start = 1'b1;
        ndone = 0; mask = 0;
        for (int c = 1; c <= 9; c++) begin
          @(negedge clk);
          if (done) begin
            ndone++;
            mask = mask | (1 << c);
            check32("b2b y", y, 32'h0000_0002);
          end
          if (c == 9) start = 1'b0;
        end
        check_int("b2b done_count", ndone, 3);
        check_int("b2b done_mask", mask, (1 << 2) | (1 << 5) | (1 << 8));
        $display("op b2b: done_count=%0d mask=%h", ndone, mask);
        repeat (4) @(negedge clk);
      end
    join_any
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
